// File: rtl/ram2_ctrl_if.sv
// Purpose : client-side command / write-data / read-data bundle for ram2_ctrl.
// Latency : n/a (wires only).
// Backpressure: cmd_ready/wdata_ready from the controller; rdata has none.
// Macro   : none.
//
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len - burst command handshake
//   wdata_valid/wdata_ready/wdata                  - write beat stream
//   rdata_valid/rdata                              - read word strobe
// master = client, slave = controller.
interface ram2_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata,
        input  cmd_ready, wdata_ready, rdata_valid, rdata
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata,
        output cmd_ready, wdata_ready, rdata_valid, rdata
    );
endinterface

// File: rtl/ram2_ctrl.sv
// Purpose : burst read/write sequencer in front of the ram2 single-port RAM;
//           owns the tristate turnaround on the shared mem_data bus.
// Latency : write beat hits the RAM one edge after acceptance; read data
//           returns 2 cycles after command accept, 1 word/cycle thereafter.
// Backpressure: cmd_ready only in IDLE; wdata_ready only in WRITE (bubbles
//           allowed); rdata_valid is a strobe with no backpressure.
// Macro   : RAM2_CTRL_INIT_CLEAR_EN - after reset, zero all RAM words before
//           accepting commands.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   bus (slave)   - client command / write / read-data interface
//   mem_ena/mem_wena/mem_addr/mem_data - direct connection to ram2
module ram2_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    ram2_ctrl_if.slave        bus,
    output logic              mem_ena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    logic [1:0]        st_q, st_d;
    logic [ADDR_W-1:0] cur_q, cur_d;     // next RAM address of the burst
    logic [ADDR_W-1:0] rem_q, rem_d;     // beats remaining minus one
    logic              ena_q, ena_d;
    logic              wena_q, wena_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;   // bus drive register
    logic              rdpend_q, rdpend_d; // read address on the bus this cycle
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvld_q, rvld_d;

    assign bus.cmd_ready   = (st_q == ST_IDLE) && !rst;
    assign bus.wdata_ready = (st_q == ST_WRITE);
    assign bus.rdata_valid = rvld_q;
    assign bus.rdata       = rdata_q;

    assign mem_ena  = ena_q;
    assign mem_wena = wena_q;
    assign mem_addr = addr_q;

    // Output enable derives from the very registers that drive ena/wena, so
    // the RAM (which drives only while ena & ~wena) and the controller can
    // never drive in the same cycle.
    assign mem_data = (ena_q && wena_q) ? wdat_q : {DATA_W{1'bz}};

    always_comb begin
        st_d     = st_q;
        cur_d    = cur_q;
        rem_d    = rem_q;
        ena_d    = 1'b0;
        wena_d   = 1'b0;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rdpend_d = 1'b0;
        rdata_d  = rdata_q;
        rvld_d   = 1'b0;

        // Capture the word the RAM is returning for last cycle's address.
        if (rdpend_q) begin
            rdata_d = mem_data;
            rvld_d  = 1'b1;
        end

        case (st_q)
            ST_IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    cur_d = bus.cmd_addr;
                    rem_d = bus.cmd_len;
                    st_d  = bus.cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                // No beat offered: leave ena low for a bubble cycle.
                if (bus.wdata_valid) begin
                    ena_d  = 1'b1;
                    wena_d = 1'b1;
                    addr_d = cur_q;
                    wdat_d = bus.wdata;
                    cur_d  = cur_q + 1'b1;
                    if (rem_q == '0) st_d = ST_IDLE;
                    else             rem_d = rem_q - 1'b1;
                end
            end
            ST_READ: begin
                ena_d    = 1'b1;
                addr_d   = cur_q;
                rdpend_d = 1'b1;
                cur_d    = cur_q + 1'b1;
                if (rem_q == '0) st_d = ST_IDLE;
                else             rem_d = rem_q - 1'b1;
            end
`ifdef RAM2_CTRL_INIT_CLEAR_EN
            ST_INIT: begin
                // Sweep every address once writing zero; cur starts at 0.
                ena_d  = 1'b1;
                wena_d = 1'b1;
                addr_d = cur_q;
                wdat_d = '0;
                cur_d  = cur_q + 1'b1;
                if (cur_q == '1) st_d = ST_IDLE;
            end
`endif
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef RAM2_CTRL_INIT_CLEAR_EN
            st_q <= ST_INIT;
`else
            st_q <= ST_IDLE;
`endif
            cur_q    <= '0;
            rem_q    <= '0;
            ena_q    <= 1'b0;
            wena_q   <= 1'b0;
            addr_q   <= '0;
            wdat_q   <= '0;
            rdpend_q <= 1'b0;
            rdata_q  <= '0;
            rvld_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            cur_q    <= cur_d;
            rem_q    <= rem_d;
            ena_q    <= ena_d;
            wena_q   <= wena_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rdpend_q <= rdpend_d;
            rdata_q  <= rdata_d;
            rvld_q   <= rvld_d;
        end
    end

endmodule
